store_lane_packer: RTL
======================

# store_lane_packer

Store-side counterpart of the immediate/load extension path: narrows a 32-bit register value to a byte, halfword or word store. It places the data on the correct little-endian byte lanes with byte enables, buffers up to two stores, and drives them to data memory over a req/ack handshake. It sits between the MEM stage and the data-memory port and flags misaligned stores as address-error (AdES) exceptions.

## Interface
Parameters:
- DEPTH, 2, store buffer entries (fixed at 2; count width 2 bits)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  store request from MEM stage
- st_ready  out  1  buffer can accept; equals (count != 2), combinational from state
- st_op  in  2  00 SB, 01 SH, 10 SW, 11 reserved
- st_addr  in  32  byte address
- st_data  in  32  register value (low bits used for SB/SH)
- mem_req  out  1  head entry valid toward memory
- mem_ack  in  1  memory accepted head this cycle
- mem_addr  out  32  word address {addr[31:2],2'b00} of head
- mem_wdata  out  32  lane-replicated write data of head
- mem_be  out  4  byte enables of head
- ades  out  1  one-cycle pulse: store address error
- badvaddr  out  32  faulting byte address; holds until the next fault
- busy  out  1  count != 0

## Operation
- Handshake: a push occurs when st_valid && st_ready && aligned. A pop occurs when mem_req && mem_ack.
- Lane packing is done at push time; the entry stores {word addr, wdata, be}:
  - SB: wdata = {4{data[7:0]}}; be = 4'b0001 << addr[1:0]
  - SH: wdata = {2{data[15:0]}}; be = addr[1] ? 4'b1100 : 4'b0011
  - SW: wdata = data; be = 4'b1111
- Alignment check:
  - SH is misaligned if addr[0] = 1.
  - SW is misaligned if addr[1:0] != 0.
  - op 11 is always treated as a fault.
- On a fault with st_valid && st_ready: no push. ades pulses high the next cycle, and badvaddr loads st_addr in the same edge.
- A fault offered while full (st_ready = 0) is ignored, because the requester must hold.
- FIFO behaviour:
  - Head pointer, tail pointer and 2-bit count; pointers wrap modulo 2.
  - Pushes and pops are in order.
  - A simultaneous push and pop leaves count unchanged.
  - No push is possible when count = 2, even if a pop occurs that cycle.
- Memory outputs:
  - mem_req = (count != 0).
  - mem_addr, mem_wdata and mem_be reflect the head entry while mem_req = 1, and are all 0 when empty.
  - Head fields are stable while mem_req = 1 && !mem_ack.
- mem_ack while mem_req = 0 is ignored.

## Timing
- Reset (rst_n low, asynchronous):
  - count = 0 and pointers = 0
  - mem_req = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0
  - ades = 0, badvaddr = 0, busy = 0
  - st_ready = 1
- Latency: a store accepted at edge N appears on mem_req/mem_* in the cycle after edge N if the buffer was empty. Otherwise it appears in the cycle after the pop of the prior entry.
- Throughput: one store per cycle when mem_ack is held high; steady state is count = 1 with a push and pop every cycle.
- ades is registered: high for exactly one cycle after the faulting offer. Back-to-back faults give back-to-back pulses, and badvaddr updates each time.
- A reset asserted mid-transaction discards all buffered entries. mem_req drops asynchronously and no partial entry survives.

## Test plan
- SB sequence: SB addr 0x1003, data 0x000000A5 -> next cycle mem_req = 1, mem_addr = 0x1000, mem_wdata = 0xA5A5A5A5, mem_be = 4'b1000; ack -> mem_req = 0, mem_be = 0.
- SH/SW lanes: SH addr 0x2002, data 0xFFFF1234 -> wdata = 0x12341234, be = 4'b1100. SW addr 0x3000, data 0xDEADBEEF -> be = 4'b1111.
- Fill and backpressure: three SW offered back-to-back with mem_ack = 0 -> st_ready = 0 after two accepted. The third store is held, then accepted the cycle after the first ack. Memory sees all three in order.
- Misalignment: SW addr 0x4001 -> no mem_req, ades = 1 for one cycle, badvaddr = 0x4001. Then SH addr 0x4005 -> ades pulses again, badvaddr = 0x4005.
- Streaming: eight SB stores with mem_ack tied to 1 -> one store per cycle, count never exceeds 1, data matches in order.
- Reset mid-operation: two entries buffered, pull rst_n low asynchronously between edges -> mem_req = 0 and busy = 0 immediately. After release, st_ready = 1 and no stale stores are issued.

Source files
------------

// File: rtl/store_lane_packer.sv
// Narrows a register value to byte/halfword/word stores with lane replication and byte
// enables, queues up to two of them for the data-memory port, and raises AdES on misalignment.
module store_lane_packer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        ades,
  output logic [31:0] badvaddr,
  output logic        busy
);

  localparam logic [1:0] OP_SB = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SW = 2'b10;

  logic [29:0] addr_q  [DEPTH];
  logic [31:0] wdata_q [DEPTH];
  logic [3:0]  be_q    [DEPTH];
  logic        head, tail;
  logic [1:0]  count;

  logic        fault, push, pop;
  logic [31:0] pk_wdata;
  logic [3:0]  pk_be;

  always_comb begin
    pk_wdata = st_data;
    pk_be    = 4'b1111;
    fault    = 1'b0;
    case (st_op)
      OP_SB: begin
        pk_wdata = {4{st_data[7:0]}};
        pk_be    = 4'b0001 << st_addr[1:0];
      end
      OP_SH: begin
        pk_wdata = {2{st_data[15:0]}};
        pk_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        fault    = st_addr[0];
      end
      OP_SW: fault = (st_addr[1:0] != 2'b00);
      default: fault = 1'b1;
    endcase
  end

  assign st_ready = (count != 2'd2);
  assign push     = st_valid && st_ready && !fault;
  assign pop      = mem_req && mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        be_q[i]    <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail]  <= st_addr[31:2];
        wdata_q[tail] <= pk_wdata;
        be_q[tail]    <= pk_be;
        tail          <= ~tail;
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Fault is only reported when the offer could have been taken; a full buffer makes the requester hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ades     <= 1'b0;
      badvaddr <= '0;
    end else begin
      ades <= st_valid && st_ready && fault;
      if (st_valid && st_ready && fault) badvaddr <= st_addr;
    end
  end

  assign mem_req   = (count != 2'd0);
  assign busy      = mem_req;
  assign mem_addr  = mem_req ? {addr_q[head], 2'b00} : 32'h0;
  assign mem_wdata = mem_req ? wdata_q[head] : 32'h0;
  assign mem_be    = mem_req ? be_q[head] : 4'h0;

endmodule
